// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage feeding pre-decode.
//
// Generates the fetch PC and issues requests on an SRAM-like instruction port
// (at most one request outstanding). Each response is packed with its PC into
// a single output register handed to pre-decode with a valid/allowin
// handshake. A one-entry skid buffer catches a response that arrives while
// the output register is still occupied. Redirects (exception entry, ertn,
// mispredict repair, pre-decode predict-taken) flush the output register and
// mark any in-flight response as stale so it is discarded on arrival.
// A misaligned fetch PC produces a single ADEF exception entry without issuing
// a request and then waits for a redirect.
//
// Optional build macro: FETCH_PERF_CNT_EN -- when defined, builds the
// perf_fetch_cnt / perf_cancel_cnt counters; otherwise both ports read zero.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   pD_allowin                 pre-decode can accept an entry this cycle
//   FpD_valid, FpD_BUS         output entry {pc, inst, pc_en, ex_F, ecode, esubcode}
//   predict_taken/_target      pre-decode predicted-taken redirect
//   predict_error/correct_target  mispredict repair redirect
//   ertn_flush/era             exception-return redirect
//   ex_en/eentry               exception-entry redirect
//   inst_req/inst_addr         request channel
//   inst_addr_ok               request accepted
//   inst_data_ok/inst_rdata    response channel
//   perf_fetch_cnt             delivered entries (optional)
//   perf_cancel_cnt            discarded responses (optional)

module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h1C000000,
    parameter int          FpD_BUS_WID = 75
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pD_allowin,
    output logic                   FpD_valid,
    output logic [FpD_BUS_WID-1:0] FpD_BUS,
    input  logic                   predict_taken,
    input  logic [31:0]            predict_target,
    input  logic                   predict_error,
    input  logic [31:0]            correct_target,
    input  logic                   ertn_flush,
    input  logic [31:0]            era,
    input  logic                   ex_en,
    input  logic [31:0]            eentry,
    output logic                   inst_req,
    output logic [31:0]            inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [31:0]            inst_rdata,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_cancel_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] ECODE_ADEF = 8'h08;

    state_t state, state_nxt;

    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] pending_pc, pending_pc_nxt;
    logic        redirect_pending, redirect_pending_nxt;
    logic        cancel, cancel_nxt;
    logic        adef_done, adef_done_nxt;

    // PC of the request currently awaiting its response
    logic [31:0] req_pc_p0, req_pc_nxt;
    // skid buffer for a response that could not enter the output register
    logic [31:0] skid_pc_p0, skid_inst_p0;
    logic        skid_we;

    logic                   out_vld_p1, out_vld_nxt;
    logic [FpD_BUS_WID-1:0] out_bus_p1, load_bus;
    logic                   load;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pc_aligned, req_active, addr_hs, out_free;

    function automatic logic [FpD_BUS_WID-1:0] pack_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        ex_f
    );
        pack_entry = {pc, inst, 1'b1, ex_f, (ex_f ? ECODE_ADEF : 8'h00), 1'b0};
    endfunction

    // Fixed-priority redirect select: ex_en > ertn_flush > predict_error > predict_taken.
    always_comb begin
        redirect    = 1'b1;
        redirect_pc = eentry;
        if (ex_en) begin
            redirect_pc = eentry;
        end else if (ertn_flush) begin
            redirect_pc = era;
        end else if (predict_error) begin
            redirect_pc = correct_target;
        end else if (predict_taken) begin
            redirect_pc = predict_target;
        end else begin
            redirect = 1'b0;
        end
    end

    assign pc_aligned = (fetch_pc[1:0] == 2'b00);
    // Gated by rstn so no request is presented while reset is held.
    assign req_active = rstn && (state == S_REQ) && pc_aligned;
    assign addr_hs    = req_active && inst_addr_ok;
    assign out_free   = !out_vld_p1 || pD_allowin;

    assign inst_req  = req_active;
    assign inst_addr = fetch_pc;

    always_comb begin
        state_nxt            = state;
        fetch_pc_nxt         = fetch_pc;
        pending_pc_nxt       = pending_pc;
        redirect_pending_nxt = redirect_pending;
        cancel_nxt           = cancel;
        adef_done_nxt        = adef_done;
        req_pc_nxt           = req_pc_p0;
        skid_we              = 1'b0;
        load                 = 1'b0;
        load_bus             = '0;

        case (state)
            S_REQ: begin
                if (!pc_aligned) begin
                    // No request goes out; emit one ADEF entry, then wait for a redirect.
                    if (redirect) begin
                        fetch_pc_nxt  = redirect_pc;
                        adef_done_nxt = 1'b0;
                    end else if (!adef_done && out_free) begin
                        load          = 1'b1;
                        load_bus      = pack_entry(fetch_pc, 32'h0, 1'b1);
                        adef_done_nxt = 1'b1;
                    end
                end else if (addr_hs) begin
                    state_nxt            = S_WAIT;
                    req_pc_nxt           = fetch_pc;
                    redirect_pending_nxt = 1'b0;
                    // The accepted address predates any redirect seen so far,
                    // so its response is wrong-path and must be dropped.
                    if (redirect) begin
                        cancel_nxt   = 1'b1;
                        fetch_pc_nxt = redirect_pc;
                    end else if (redirect_pending) begin
                        cancel_nxt   = 1'b1;
                        fetch_pc_nxt = pending_pc;
                    end else begin
                        fetch_pc_nxt = fetch_pc + 32'd4;
                    end
                end else if (redirect) begin
                    // inst_addr must stay stable until accepted; park the target.
                    pending_pc_nxt       = redirect_pc;
                    redirect_pending_nxt = 1'b1;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_nxt = redirect_pc;
                end
                if (inst_data_ok) begin
                    cancel_nxt = 1'b0;
                    if (cancel || redirect) begin
                        state_nxt = S_REQ;
                    end else if (out_free) begin
                        load      = 1'b1;
                        load_bus  = pack_entry(req_pc_p0, inst_rdata, 1'b0);
                        state_nxt = S_REQ;
                    end else begin
                        skid_we   = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end else if (redirect) begin
                    cancel_nxt = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    fetch_pc_nxt = redirect_pc;
                    state_nxt    = S_REQ;
                end else if (out_free) begin
                    load      = 1'b1;
                    load_bus  = pack_entry(skid_pc_p0, skid_inst_p0, 1'b0);
                    state_nxt = S_REQ;
                end
            end

            default: state_nxt = S_REQ;
        endcase

        if (redirect) begin
            out_vld_nxt = 1'b0;
        end else if (load) begin
            out_vld_nxt = 1'b1;
        end else if (pD_allowin) begin
            out_vld_nxt = 1'b0;
        end else begin
            out_vld_nxt = out_vld_p1;
        end
    end

    // ---- request stage (p0) ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= S_REQ;
            fetch_pc         <= RESET_PC;
            redirect_pending <= 1'b0;
            cancel           <= 1'b0;
            adef_done        <= 1'b0;
        end else begin
            state            <= state_nxt;
            fetch_pc         <= fetch_pc_nxt;
            redirect_pending <= redirect_pending_nxt;
            cancel           <= cancel_nxt;
            adef_done        <= adef_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        pending_pc <= pending_pc_nxt;
        req_pc_p0  <= req_pc_nxt;
        if (skid_we) begin
            skid_pc_p0   <= req_pc_p0;
            skid_inst_p0 <= inst_rdata;
        end
    end

    // ---- output stage (p1) ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_vld_p1 <= 1'b0;
            out_bus_p1 <= '0;
        end else begin
            out_vld_p1 <= out_vld_nxt;
            if (load) begin
                out_bus_p1 <= load_bus;
            end
        end
    end

    assign FpD_valid = out_vld_p1;
    assign FpD_BUS   = out_bus_p1;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, cancel_cnt;
    logic        drop_data;

    assign drop_data = (state == S_WAIT) && inst_data_ok && (cancel || redirect);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_cnt  <= 32'h0;
            cancel_cnt <= 32'h0;
        end else begin
            if (out_vld_p1 && pD_allowin) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (drop_data) begin
                cancel_cnt <= cancel_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = fetch_cnt;
    assign perf_cancel_cnt = cancel_cnt;
`else
    assign perf_fetch_cnt  = 32'h0;
    assign perf_cancel_cnt = 32'h0;
`endif

endmodule
